// File: rtl/step_counter.sv
// step_counter: up/down counter with constant step, parallel load and configurable reset value
// Ports: clk_i clock; reset_i async active-low reset; up_i/down_i step requests;
//        load_i/loaded_val_i parallel load (highest priority); counter_o registered count;
//        step_o/reset_val_o exported constants (truncated to width_p bits).
`timescale 1ns/1ps
module step_counter #(
  parameter int width_p = 8,
  parameter reset_val_p = 0,
  parameter step_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               load_i,
  input  logic [width_p-1:0] loaded_val_i,
  output logic [width_p-1:0] counter_o,
  output logic [width_p-1:0] step_o,
  output logic [width_p-1:0] reset_val_o
);
  localparam logic [width_p-1:0] reset_val_lp = width_p'(reset_val_p);
  localparam logic [width_p-1:0] step_lp = width_p'(step_p);
  logic [width_p-1:0] count_q, count_d;
  // up and down together cancel; arithmetic wraps modulo 2^width_p
  always_comb
    count_d = load_i            ? loaded_val_i :
              up_i && !down_i   ? count_q + step_lp :
              down_i && !up_i   ? count_q - step_lp : count_q;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) count_q <= reset_val_lp;
    else          count_q <= count_d;
  assign counter_o   = count_q;
  assign step_o      = step_lp;
  assign reset_val_o = reset_val_lp;
  if ((reset_val_p >> width_p) != 0) begin : g_reset_val_trunc
    $warning("step_counter: reset_val_p truncated to width_p bits");
  end
  if ((step_p >> width_p) != 0) begin : g_step_trunc
    $warning("step_counter: step_p truncated to width_p bits");
  end
endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: directed scoreboard bench for step_counter in two configurations
`timescale 1ns/1ps
module tb_step_counter;
  logic clk = 1'b0;
  logic rst_a_n, up_a, dn_a, ld_a;
  logic [9:0] lv_a, cnt_a, step_a, rv_a;
  logic rst_b_n, up_b, dn_b, ld_b;
  logic [1:0] lv_b, cnt_b, step_b, rv_b;
  int tests = 0, fails = 0;
  int qa[$], qb[$];
  int last_a, last_b;
  always #5 clk = ~clk;
  step_counter #(.width_p(10), .reset_val_p(249), .step_p(10)) dut_a (
    .clk_i(clk), .reset_i(rst_a_n), .up_i(up_a), .down_i(dn_a), .load_i(ld_a),
    .loaded_val_i(lv_a), .counter_o(cnt_a), .step_o(step_a), .reset_val_o(rv_a));
  step_counter #(.width_p(2), .reset_val_p(2), .step_p(1)) dut_b (
    .clk_i(clk), .reset_i(rst_b_n), .up_i(up_b), .down_i(dn_b), .load_i(ld_b),
    .loaded_val_i(lv_b), .counter_o(cnt_b), .step_o(step_b), .reset_val_o(rv_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc_a(input string tag, input logic u, input logic d, input logic l,
                       input logic [9:0] v, input int exp);
    @(negedge clk);
    up_a = u; dn_a = d; ld_a = l; lv_a = v;
    qa.push_back(exp);
    #1 chk({tag, "_nocomb"}, {22'b0, cnt_a}, last_a);
    @(posedge clk);
    #1 last_a = qa.pop_front();
    chk(tag, {22'b0, cnt_a}, last_a);
    chk({tag, "_step_o"}, {22'b0, step_a}, 10);
    chk({tag, "_reset_val_o"}, {22'b0, rv_a}, 249);
  endtask
  task automatic cyc_b(input string tag, input logic u, input logic d, input logic l,
                       input logic [1:0] v, input int exp);
    @(negedge clk);
    up_b = u; dn_b = d; ld_b = l; lv_b = v;
    qb.push_back(exp);
    #1 chk({tag, "_nocomb"}, {30'b0, cnt_b}, last_b);
    @(posedge clk);
    #1 last_b = qb.pop_front();
    chk(tag, {30'b0, cnt_b}, last_b);
  endtask
  initial begin
    rst_a_n = 1'b1; up_a = 1'b0; dn_a = 1'b0; ld_a = 1'b0; lv_a = '0;
    rst_b_n = 1'b1; up_b = 1'b0; dn_b = 1'b0; ld_b = 1'b0; lv_b = '0;
    #1;
    chk("a_step_o_t0", {22'b0, step_a}, 10);
    chk("a_reset_val_o_t0", {22'b0, rv_a}, 249);
    chk("b_step_o_t0", {30'b0, step_b}, 1);
    chk("b_reset_val_o_t0", {30'b0, rv_b}, 2);
    #2 rst_a_n = 1'b0; rst_b_n = 1'b0;
    #1;
    chk("a_async_reset", {22'b0, cnt_a}, 249);
    chk("b_async_reset", {30'b0, cnt_b}, 2);
    last_a = 249;
    last_b = 2;
    cyc_a("a_reset_ignores_reqs", 1'b1, 1'b0, 1'b1, 10'd7, 249);
    @(negedge clk);
    up_a = 1'b0; ld_a = 1'b0; rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk);
    #1 chk("a_after_release", {22'b0, cnt_a}, 249);
    chk("b_after_release", {30'b0, cnt_b}, 2);
    cyc_a("a_up1", 1'b1, 1'b0, 1'b0, 10'd0, 259);
    cyc_a("a_up2", 1'b1, 1'b0, 1'b0, 10'd0, 269);
    cyc_a("a_up3", 1'b1, 1'b0, 1'b0, 10'd0, 279);
    cyc_a("a_down", 1'b0, 1'b1, 1'b0, 10'd0, 269);
    cyc_a("a_both_hold", 1'b1, 1'b1, 1'b0, 10'd0, 269);
    cyc_a("a_idle_hold", 1'b0, 1'b0, 1'b0, 10'd0, 269);
    cyc_a("a_load_over_up", 1'b1, 1'b0, 1'b1, 10'd500, 500);
    cyc_a("a_down_from_load", 1'b0, 1'b1, 1'b0, 10'd0, 490);
    cyc_a("a_load_1020", 1'b0, 1'b1, 1'b1, 10'd1020, 1020);
    cyc_a("a_up_wrap", 1'b1, 1'b0, 1'b0, 10'd0, 6);
    cyc_a("a_down_wrap", 1'b0, 1'b1, 1'b0, 10'd0, 1020);
    @(negedge clk);
    up_a = 1'b0; dn_a = 1'b0; ld_a = 1'b0;
    cyc_b("b_up1", 1'b1, 1'b0, 1'b0, 2'd0, 3);
    cyc_b("b_up_wrap", 1'b1, 1'b0, 1'b0, 2'd0, 0);
    cyc_b("b_down_wrap", 1'b0, 1'b1, 1'b0, 2'd0, 3);
    @(negedge clk);
    dn_b = 1'b0; up_b = 1'b1;
    #2 rst_b_n = 1'b0;
    #1 chk("b_midop_reset", {30'b0, cnt_b}, 2);
    @(posedge clk);
    #1 chk("b_reset_discards_up", {30'b0, cnt_b}, 2);
    chk("b_step_o_in_reset", {30'b0, step_b}, 1);
    chk("b_reset_val_o_in_reset", {30'b0, rv_b}, 2);
    @(negedge clk);
    rst_b_n = 1'b1;
    qb.push_back(3);
    @(posedge clk);
    #1 last_b = qb.pop_front();
    chk("b_release_up", {30'b0, cnt_b}, last_b);
    cyc_b("b_load_over_down", 1'b0, 1'b1, 1'b1, 2'd1, 1);
    cyc_b("b_both_hold", 1'b1, 1'b1, 1'b0, 2'd0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/step_counter.md
# step_counter

Parameterized synchronous up/down counter with a fixed step size, parallel load and a configurable reset value. It is the shared counting primitive used by gameplay blocks such as the player ship, for lives and for horizontal position. Each enabled cycle moves the count by a constant step. The configured step and reset value are exported so neighbouring logic can use them without re-declaring the constants.

## Interface
Parameters:
- width_p, default 8: counter width in bits; legal range ≥ 1.
- reset_val_p, default 0 (width_p bits): value loaded on reset.
- step_p, default 1 (width_p bits): amount added or subtracted per enabled cycle.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge except reset.
- reset_i  input  1  one clock; reset is asynchronous and active-low (reset_i = 0 forces reset immediately, release is sampled by clk_i).
- up_i  input  1  increment request.
- down_i  input  1  decrement request.
- load_i  input  1  parallel-load request.
- loaded_val_i  input  width_p  value captured when load_i is taken.
- counter_o  output  width_p  current count, driven directly from the state register.
- step_o  output  width_p  constant, equal to step_p.
- reset_val_o  output  width_p  constant, equal to reset_val_p.

## Operation
- State: one width_p-bit register, count.
- Reset behaviour:
  - While reset_i = 0, count = reset_val_p, independent of clk_i and of all other inputs.
  - Outputs during reset: counter_o = reset_val_p; step_o and reset_val_o hold their constants.
- Next-state priority, evaluated on each rising clk_i edge with reset_i = 1:
  1. load_i = 1: count ← loaded_val_i; up_i and down_i are ignored.
  2. up_i = 1 and down_i = 0: count ← count + step_p.
  3. up_i = 0 and down_i = 1: count ← count − step_p.
  4. up_i = down_i (both 0 or both 1): count holds.
- Arithmetic:
  - Unsigned, modulo 2^width_p.
  - Overflow and underflow wrap with no saturation and no flag.
  - Callers gate up_i and down_i with their own bounds checks.
- Outputs are purely registered or constant; there is no combinational path from any input to counter_o.
- Illegal parameter values (step_p or reset_val_p ≥ 2^width_p) are truncated to width_p bits. A simulation-only assertion flags a truncated value at elaboration.

## Timing
- Latency: a request presented in cycle N is visible on counter_o after the rising edge that ends cycle N, which is one cycle.
- No handshake: every request is accepted on every edge, and there is no busy or valid signalling.
- Reset assertion mid-operation:
  - Overrides immediately.
  - Any pending load, up or down request in that cycle is discarded.
- Reset release: the first edge with reset_i = 1 applies normal priority rules, starting from reset_val_p.
- step_o and reset_val_o are static from time zero, including during reset.

## Test plan
- Reset, with width_p = 10, reset_val_p = 249, step_p = 10:
  - Drive reset_i = 0 asynchronously mid-cycle → counter_o = 249 before the next clk_i edge.
  - Same configuration → step_o = 10 and reset_val_o = 249 at all times.
- Stepping, same configuration:
  - up_i held high for 3 edges from 249 → 259, 269, 279.
  - down_i held high for 1 edge from 279 → 269.
  - up_i and down_i both high for 1 edge → count holds.
- Load priority: load_i = 1, loaded_val_i = 500, up_i = 1 → counter_o = 500 on the next edge; up_i has no effect.
- Wrap-around, with width_p = 2, reset_val_p = 2, step_p = 1:
  - up_i for 2 edges → 3, then 0.
  - down_i for 1 edge from 0 → 3.
- Reset mid-operation: from count 3, assert reset_i = 0 while up_i = 1 → count = 2 immediately. Release reset with up_i = 1 → 3 on the first following edge.
